pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter SHOW_TICKS, default 4, number of tick pulses each generated value is held on led.
REQ-002 Parameter GAP_TICKS, default 1, number of tick pulses led is held blank between values.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 clr  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a round; sampled only in IDLE.
REQ-007 level  in  4  number of values in the round; latched on accepted start.
REQ-008 tick  in  1  one-cycle rate-enable pulse that paces display timing.
REQ-009 d  out  10  write data to the downstream number memory.
REQ-010 wn  out  4  write slot index, 0..9.
REQ-011 we  out  1  write enable, one cycle per write.
REQ-012 led  out  10  value currently shown to the player.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a round completes.

Function
REQ-015 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) SHALL advance every clk cycle in all states, so start timing seeds the round.
REQ-016 States SHALL be IDLE, WIPE, GEN, SHOW, GAP, FIN.
REQ-017 IDLE: led=0, we=0; start=1 latches level, clears idx and the internal history, and enters WIPE next cycle.
REQ-018 level=0 SHALL latch as 1; level>10 SHALL latch as 10.
REQ-019 WIPE: 10 consecutive cycles with we=1, d=0, wn=0..9 ascending, then GEN.
REQ-020 GEN: candidate = LFSR[9:0]; the candidate is valid iff nonzero and unequal to every history entry 0..idx-1.
REQ-021 GEN, invalid candidate: we=0, stay in GEN (retry next cycle with the advanced LFSR).
REQ-022 GEN, valid candidate: same cycle we=1, wn=idx, d=candidate; store the candidate in history[idx]; led=candidate from the next cycle; go SHOW with the tick counter cleared.
REQ-023 SHOW: led holds the value; after SHOW_TICKS tick pulses, go GAP with the counter cleared.
REQ-024 GAP: led=0; after GAP_TICKS tick pulses, idx increments; if new idx equals latched level go FIN, else GEN.
REQ-025 GAP_TICKS=0 SHALL skip GAP (SHOW exits directly through the GAP decision, one cycle, led=0).
REQ-026 FIN: done=1 for exactly one cycle, led=0, then IDLE.
REQ-027 we SHALL be high only in WIPE and in GEN on a valid candidate; never two writes to the same slot within a round after WIPE.
REQ-028 start while busy SHALL be ignored; level changes while busy SHALL have no effect.
REQ-029 tick counts only in SHOW/GAP; ticks in other states SHALL be ignored.
REQ-030 d and wn SHALL be 0 whenever we=0.

Reset
REQ-031 clr=1 SHALL immediately force IDLE, idx=0, history cleared, LFSR=LFSR_SEED, led=0, d=0, wn=0, we=0, busy=0, done=0, regardless of state.
REQ-032 clr asserted mid-round SHALL abort without further writes; the next round starts with a full WIPE.

Verification
REQ-033 Reset then start with level=3, tick every cycle -> 10 WIPE writes (d=0, wn 0..9), then 3 writes wn=0,1,2 of distinct nonzero values, each shown for 4 ticks and blanked for 1, then one done pulse.
REQ-034 Force LFSR[9:0]=0 or a duplicate of history[0] via seed/timing -> no write that cycle, GEN persists, and the next valid value is written to the same wn.
REQ-035 level=0 -> exactly one value write; level=15 -> exactly ten value writes, wn 0..9.
REQ-036 Pulse start during SHOW with level=7 -> ignored; round finishes with the original level count; busy is low only after done.
REQ-037 Assert clr during SHOW of value 2 -> all outputs 0 within the same cycle; a new start repeats WIPE from wn=0.
REQ-038 tick held low in SHOW -> led holds the value indefinitely, no writes, and no done.

Source files
------------

// File: rtl/pattern_gen.sv
// Round generator: writes distinct nonzero 10-bit values from a free-running LFSR into
// slots 0..level-1 after a full wipe, showing each value on led for a tick-paced interval.
module pattern_gen #(
  parameter int unsigned SHOW_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] level,
  input  logic       tick,
  output logic [9:0] d,
  output logic [3:0] wn,
  output logic       we,
  output logic [9:0] led,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WIPE = 3'd1;
  localparam logic [2:0] S_GEN  = 3'd2;
  localparam logic [2:0] S_SHOW = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam int CW = 8;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [2:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    lvl_q, lvl_d;
  logic [3:0]    wipe_q, wipe_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    led_q, led_d;
  logic [9:0]    hist_q [10];
  logic          hist_clr, hist_wr;
  logic [9:0]    cand;
  logic          dup, cand_ok, gap_exit;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign cand   = lfsr_q[9:0];

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ((4'(i) < idx_q) && (hist_q[i] == cand)) dup = 1'b1;
    end
  end

  assign cand_ok = (cand != 10'd0) && !dup;
  assign led     = led_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lvl_d    = lvl_q;
    wipe_d   = wipe_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    hist_clr = 1'b0;
    hist_wr  = 1'b0;
    gap_exit = 1'b0;
    we       = 1'b0;
    wn       = 4'd0;
    d        = 10'd0;
    case (state_q)
      S_IDLE: begin
        led_d = 10'd0;
        if (start) begin
          lvl_d    = (level == 4'd0) ? 4'd1 : ((level > 4'd10) ? 4'd10 : level);
          idx_d    = 4'd0;
          wipe_d   = 4'd0;
          hist_clr = 1'b1;
          state_d  = S_WIPE;
        end
      end
      S_WIPE: begin
        we = 1'b1;
        wn = wipe_q;
        if (wipe_q == 4'd9) state_d = S_GEN;
        else                wipe_d  = wipe_q + 4'd1;
      end
      S_GEN: begin
        if (cand_ok) begin
          we      = 1'b1;
          wn      = idx_q;
          d       = cand;
          hist_wr = 1'b1;
          led_d   = cand;
          cnt_d   = '0;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d   = '0;
            led_d   = 10'd0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GAP: begin
        // a zero-tick gap still spends this one blank cycle making the decision
        gap_exit = (GAP_TICKS == 0) || (tick && (cnt_q == GAP_LAST));
        if (tick) cnt_d = cnt_q + CW'(1);
        if (gap_exit) begin
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
          state_d = ((idx_q + 4'd1) == lvl_q) ? S_FIN : S_GEN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= 4'd0;
      lvl_q   <= 4'd1;
      wipe_q  <= 4'd0;
      cnt_q   <= '0;
      led_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      wipe_q  <= wipe_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 10; i++) hist_q[i] <= 10'd0;
    end else if (hist_clr) begin
      for (int i = 0; i < 10; i++) hist_q[i] <= 10'd0;
    end else if (hist_wr) begin
      hist_q[idx_q] <= cand;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: records every cycle, then replays the recording through a round-level model.
module tb_pattern_gen;

  localparam int SHOW = 4;
  localparam int GAP  = 1;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int MAXR = 40000;
  localparam int SLEN = 25010;

  logic clk = 1'b0, clr = 1'b1, start = 1'b0, tick = 1'b0;
  logic [3:0] level = 4'd0;
  logic [9:0] d, led;
  logic [3:0] wn;
  logic we, busy, done;

  pattern_gen #(.SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .LFSR_SEED(SEED)) dut (
    .clk(clk), .clr(clr), .start(start), .level(level), .tick(tick),
    .d(d), .wn(wn), .we(we), .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // output record layout: {we, wn, d, led, busy, done}
  function automatic logic [26:0] pk(logic w, logic [3:0] n, logic [9:0] dd, logic [9:0] l, logic b, logic dn);
    return {w, n, dd, l, b, dn};
  endfunction

  // polynomial exponents 16, 14, 13, 11 in right-shift Galois form
  function automatic logic [15:0] lfsr_adv(logic [15:0] s);
    logic [15:0] mask;
    mask = (16'd1 << (16 - 1)) | (16'd1 << (14 - 1)) | (16'd1 << (13 - 1)) | (16'd1 << (11 - 1));
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge clr) begin
    if (clr) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_adv(m_lfsr);
  end

  logic [26:0] rec_out [MAXR];
  logic [26:0] exp_out [MAXR];
  logic        rec_start [MAXR];
  logic        rec_tick [MAXR];
  logic [3:0]  rec_level [MAXR];
  logic [15:0] rec_lfsr [MAXR];
  logic [15:0] strm [SLEN];
  int n_rec, n_cmp, n_fail;

  typedef struct {
    logic [3:0] lv;
    int         writes;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic [3:0] lv, input logic tk);
    start = st;
    level = lv;
    tick  = tk;
    #1;
    if (n_rec < MAXR) begin
      rec_out[n_rec]   = pk(we, wn, d, led, busy, done);
      rec_start[n_rec] = st;
      rec_tick[n_rec]  = tk;
      rec_level[n_rec] = lv;
      rec_lfsr[n_rec]  = m_lfsr;
      n_rec++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    clr   = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    #1;
    check(name, pk(we, wn, d, led, busy, done), 27'd0);
    @(negedge clk);
    clr   = 1'b0;
    n_rec = 0;
  endtask

  task automatic put(input int t, input logic [26:0] v);
    if (t < n_rec) exp_out[t] = v;
  endtask

  // One round starting at an accepted start in cycle c; returns the first cycle after FIN.
  task automatic model_round(input int c, output int tn);
    int t, lv, cnt, hn;
    logic [9:0] hist [10];
    logic [9:0] cand;
    logic ok;
    lv = int'(rec_level[c]);
    if (lv == 0) lv = 1;
    if (lv > 10) lv = 10;
    hn = 0;
    put(c, 27'd0);
    t = c + 1;
    for (int k = 0; k < 10; k++) begin
      put(t, pk(1'b1, 4'(k), 10'd0, 10'd0, 1'b1, 1'b0));
      t++;
    end
    for (int idx = 0; idx < lv; idx++) begin
      while (t < n_rec) begin
        cand = rec_lfsr[t][9:0];
        ok = (cand != 10'd0);
        for (int j = 0; j < hn; j++) if (hist[j] == cand) ok = 1'b0;
        if (ok) break;
        put(t, pk(1'b0, 4'd0, 10'd0, 10'd0, 1'b1, 1'b0));
        t++;
      end
      cand = rec_lfsr[t][9:0];
      put(t, pk(1'b1, 4'(idx), cand, 10'd0, 1'b1, 1'b0));
      hist[hn] = cand;
      hn++;
      t++;
      cnt = 0;
      while (cnt < SHOW && t < n_rec) begin
        put(t, pk(1'b0, 4'd0, 10'd0, cand, 1'b1, 1'b0));
        if (rec_tick[t]) cnt++;
        t++;
      end
      cnt = 0;
      do begin
        put(t, pk(1'b0, 4'd0, 10'd0, 10'd0, 1'b1, 1'b0));
        if (rec_tick[t]) cnt++;
        t++;
      end while (cnt < GAP && t < n_rec);
    end
    put(t, pk(1'b0, 4'd0, 10'd0, 10'd0, 1'b1, 1'b1));
    tn = t + 1;
  endtask

  task automatic build_and_check(input string tag);
    int t, tn;
    t = 0;
    while (t < n_rec) begin
      if (rec_start[t]) begin
        model_round(t, tn);
        t = tn;
      end else begin
        put(t, 27'd0);
        t++;
      end
    end
    for (int i = 0; i < n_rec; i++) check($sformatf("%s cyc %0d", tag, i), rec_out[i], exp_out[i]);
  endtask

  function automatic int count_vw();
    int n = 0;
    for (int i = 0; i < n_rec; i++) if (rec_out[i][26] && rec_out[i][21:12] != 10'd0) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    for (int i = 0; i < n_rec; i++) if (rec_out[i][0]) n++;
    return n;
  endfunction

  task automatic run_round(input string tag, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      cyc(1'b0, 4'($urandom), 1'b1);
      if (rec_out[n_rec-1][0]) seen = 1;
    end
    cyc(1'b0, 4'd0, 1'b1);
    check_int({tag, " finished"}, int'(seen), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kz, kd, w1, w2;
    logic [15:0] s;
    n_cmp = 0;
    n_fail = 0;
    n_rec = 0;
    tbl[0] = '{4'd3, 3};
    tbl[1] = '{4'd0, 1};
    tbl[2] = '{4'd1, 1};
    tbl[3] = '{4'd10, 10};
    tbl[4] = '{4'd11, 10};
    tbl[5] = '{4'd15, 10};
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_reset("reset");
      cyc(1'b1, tbl[i].lv, 1'b1);
      run_round($sformatf("tbl%0d", i), 400);
      build_and_check($sformatf("tbl%0d", i));
      check_int($sformatf("tbl%0d writes", i), count_vw(), tbl[i].writes);
      check_int($sformatf("tbl%0d done", i), count_done(), 1);
    end

    for (int r = 0; r < 3; r++) begin
      do_reset("reset");
      for (int k = 0; k < 1500; k++) cyc(($urandom % 16) == 0, 4'($urandom), ($urandom % 3) != 0);
      build_and_check($sformatf("rand%0d", r));
    end

    // start with a different level while showing must be ignored
    do_reset("reset");
    cyc(1'b1, 4'd3, 1'b1);
    for (int k = 0; k < 100 && count_vw() == 0; k++) cyc(1'b0, 4'd3, 1'b1);
    cyc(1'b0, 4'd3, 1'b1);
    cyc(1'b1, 4'd7, 1'b1);
    run_round("busy_start", 400);
    build_and_check("busy_start");
    check_int("busy_start writes", count_vw(), 3);
    check_int("busy_start done", count_done(), 1);

    // clear while the second value is on display, then a fresh round re-wipes
    do_reset("reset");
    cyc(1'b1, 4'd3, 1'b1);
    for (int k = 0; k < 200 && count_vw() < 2; k++) cyc(1'b0, 4'd3, 1'b1);
    cyc(1'b0, 4'd3, 1'b1);
    check_int("clr_mid writes before", count_vw(), 2);
    build_and_check("clr_mid pre");
    do_reset("clr_mid outputs");
    cyc(1'b1, 4'd3, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 4'd3, 1'b1);
    check("clr_mid rewipe slot0", rec_out[1], pk(1'b1, 4'd0, 10'd0, 10'd0, 1'b1, 1'b0));
    build_and_check("clr_mid post");

    // no ticks: the first value stays up forever
    do_reset("reset");
    cyc(1'b1, 4'd5, 1'b0);
    for (int k = 0; k < 300; k++) cyc(1'b0, 4'd5, 1'b0);
    build_and_check("notick");
    check_int("notick writes", count_vw(), 1);
    check_int("notick done", count_done(), 0);

    s = SEED;
    for (int i = 0; i < SLEN; i++) begin
      strm[i] = s;
      s = lfsr_adv(s);
    end
    kz = -1;
    kd = -1;
    for (int i = 11; i < SLEN - 7; i++) begin
      if (kz < 0 && strm[i][9:0] == 10'd0) kz = i;
      if (kd < 0 && strm[i][9:0] != 10'd0 && strm[i+6][9:0] == strm[i][9:0]) kd = i;
    end

    // GEN entered on an all-zero candidate
    if (kz >= 0) begin
      do_reset("reset");
      for (int k = 0; k < kz - 11; k++) cyc(1'b0, 4'd1, 1'b1);
      cyc(1'b1, 4'd1, 1'b1);
      for (int k = 0; k < 40; k++) cyc(1'b0, 4'd1, 1'b1);
      build_and_check("zero");
      check("zero no write", rec_out[kz], pk(1'b0, 4'd0, 10'd0, 10'd0, 1'b1, 1'b0));
      check_int("zero writes", count_vw(), 1);
    end

    // second GEN entered on a repeat of the first value
    if (kd >= 0) begin
      do_reset("reset");
      for (int k = 0; k < kd - 11; k++) cyc(1'b0, 4'd2, 1'b1);
      cyc(1'b1, 4'd2, 1'b1);
      for (int k = 0; k < 40; k++) cyc(1'b0, 4'd2, 1'b1);
      build_and_check("dup");
      check("dup no write", rec_out[kd+6], pk(1'b0, 4'd0, 10'd0, 10'd0, 1'b1, 1'b0));
      w1 = -1;
      w2 = -1;
      for (int i = 0; i < n_rec; i++) begin
        if (rec_out[i][26] && rec_out[i][21:12] != 10'd0) begin
          if (w1 < 0) w1 = i;
          else if (w2 < 0) w2 = i;
        end
      end
      check_int("dup first write cycle", w1, kd);
      check_int("dup second write after retry", int'(w2 > kd + 6), 1);
      if (w2 >= 0) check_int("dup second slot", int'(rec_out[w2][25:22]), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
